xpmwrap_spram_arbiter: RTL and testbench
========================================

XPMWRAP_SPRAM_ARBITER -- requirements
Module: xpmwrap_spram_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH_A, 6, RAM word address width; DATA_WIDTH_A, 32, read/write data width; BYTE_WRITE_WIDTH_A, 8, bits per wea lane; IDLE_CYCLES, 16, idle cycles before sleep (0 = sleep never used); WAKE_CYCLES, 2, cycles sleep is held low before first grant.
REQ-002 SHALL have ports (NB = DATA_WIDTH_A/BYTE_WRITE_WIDTH_A), clock and reset first: clka in 1 clock; rsta in 1 reset, asynchronous, active-high.
REQ-003 SHALL have, per requester k in {0,1}: mk_req in 1 access request; mk_we in NB byte write mask (all-zero = read); mk_addr in ADDR_WIDTH_A address; mk_wdata in DATA_WIDTH_A write data; mk_gnt out 1 access accepted this cycle; mk_rvalid out 1 read data valid; mk_rdata out DATA_WIDTH_A read data.
REQ-004 SHALL have RAM-side ports: ram_ena out 1; ram_wea out NB; ram_addra out ADDR_WIDTH_A; ram_dina out DATA_WIDTH_A; ram_regcea out 1; ram_sleep out 1; ram_douta in DATA_WIDTH_A (RAM read latency 2).

Function
REQ-005 SHALL grant at most one requester per cycle; mk_gnt is combinational from mk_req and state, same cycle; a request is consumed only on mk_req && mk_gnt.
REQ-006 SHALL, on a grant, drive ram_ena=1 and ram_wea/ram_addra/ram_dina from the granted requester that cycle; otherwise ram_ena=0, ram_wea=0.
REQ-007 SHALL drive ram_regcea=1 constantly.
REQ-008 SHALL carry a 2-stage {valid, owner} tag pipeline for granted reads (mk_we==0); mk_rvalid SHALL pulse exactly 2 cycles after the read grant, only for the owner, with mk_rdata=ram_douta.
REQ-009 SHALL drive mk_rdata = ram_douta for both requesters always; only mk_rvalid qualifies it.
REQ-010 SHALL not produce rvalid for writes (any mk_we bit set), including partial-byte writes.
REQ-011 SHALL support back-to-back grants every cycle; read data returns in grant order.
REQ-012 SHALL implement power FSM states ACTIVE, SLEEP, WAKE; grants only in ACTIVE.
REQ-013 ACTIVE->SLEEP when IDLE_CYCLES!=0, idle counter reaches IDLE_CYCLES, tag pipeline empty; idle counter increments each cycle with no mk_req, clears on any mk_req, saturates.
REQ-014 In SLEEP ram_sleep=1; SLEEP->WAKE on any mk_req; WAKE holds ram_sleep=0, gnt=0 for WAKE_CYCLES cycles, then ->ACTIVE with idle counter cleared.
REQ-015 A request arriving in the same cycle ACTIVE->SLEEP would be taken SHALL win: no transition, request granted.
REQ-016 Requests in SLEEP/WAKE SHALL stay pending (requester holds mk_req) and receive no gnt.

Reset
REQ-017 rsta SHALL asynchronously force: FSM=ACTIVE, idle counter=0, tag pipeline empty, round-robin pointer=requester 1 (so m0 wins first tie), ram_sleep=0.
REQ-018 Outputs during and immediately after reset: mk_gnt=0 while rsta=1, mk_rvalid=0, ram_ena=0, ram_wea=0; reads in flight at reset SHALL never return rvalid.

Configuration
REQ-019 Macro XPMWRAP_SPRAM_ARB_RR_EN defined: round-robin; on simultaneous requests grant the requester not granted most recently; pointer updates on every grant.
REQ-020 Macro XPMWRAP_SPRAM_ARB_RR_EN undefined: fixed priority, m0 always wins ties; no pointer register.

Verification
REQ-021 m0 write addr 5 data 0xA1B2C3D4 we 4'b1111, then m0 read addr 5 -> m0_rvalid 2 cycles after read grant, m0_rdata 0xA1B2C3D4, m1_rvalid 0.
REQ-022 Byte write m1 addr 5 data 0x000000EE we 4'b0001, m1 read addr 5 -> m1_rdata 0xA1B2C3EE; no rvalid for the write.
REQ-023 Both req held 4 cycles (reads addr 1/2), RR_EN defined -> grants m0,m1,m0,m1; rvalids alternate 2 cycles later; undefined -> m0 granted all 4, m1 none.
REQ-024 IDLE_CYCLES=16, WAKE_CYCLES=2: no req 16 cycles -> ram_sleep=1; m0_req asserted -> ram_sleep=0 next cycle, m0_gnt first high 2 cycles later, then read data correct.
REQ-025 m0 read granted, rsta pulsed 1 cycle next cycle -> no m0_rvalid; all outputs at reset values; next request granted normally.

Source files
------------

// File: rtl/xpmwrap_spram_arbiter.sv
// rtl/xpmwrap_spram_arbiter.sv - two-port arbiter with power FSM in front of a single-port RAM (latency 2)
// Optional XPMWRAP_SPRAM_ARB_RR_EN selects round-robin tie-break; default is fixed m0 priority.
module xpmwrap_spram_arbiter #(
    parameter int ADDR_WIDTH_A       = 6,
    parameter int DATA_WIDTH_A       = 32,
    parameter int BYTE_WRITE_WIDTH_A = 8,
    parameter int IDLE_CYCLES        = 16,
    parameter int WAKE_CYCLES        = 2,
    localparam int NB = DATA_WIDTH_A / BYTE_WRITE_WIDTH_A
) (
    input  logic                    clka,
    input  logic                    rsta,
    input  logic                    m0_req,
    input  logic [NB-1:0]           m0_we,
    input  logic [ADDR_WIDTH_A-1:0] m0_addr,
    input  logic [DATA_WIDTH_A-1:0] m0_wdata,
    output logic                    m0_gnt,
    output logic                    m0_rvalid,
    output logic [DATA_WIDTH_A-1:0] m0_rdata,
    input  logic                    m1_req,
    input  logic [NB-1:0]           m1_we,
    input  logic [ADDR_WIDTH_A-1:0] m1_addr,
    input  logic [DATA_WIDTH_A-1:0] m1_wdata,
    output logic                    m1_gnt,
    output logic                    m1_rvalid,
    output logic [DATA_WIDTH_A-1:0] m1_rdata,
    output logic                    ram_ena,
    output logic [NB-1:0]           ram_wea,
    output logic [ADDR_WIDTH_A-1:0] ram_addra,
    output logic [DATA_WIDTH_A-1:0] ram_dina,
    output logic                    ram_regcea,
    output logic                    ram_sleep,
    input  logic [DATA_WIDTH_A-1:0] ram_douta
);

    typedef enum logic [1:0] {ST_ACTIVE, ST_SLEEP, ST_WAKE} state_t;

    localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES + 1) : 1;
    localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYCLES);
    localparam logic [IW-1:0] IDLE_LAST = IW'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
    localparam logic [WW-1:0] WAKE_LAST = WW'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

    state_t        state;
    logic [IW-1:0] idle_cnt;
    logic [WW-1:0] wake_cnt;
    logic          tag0_v, tag0_own, tag1_v, tag1_own;
    logic          any_req, open, sel1, gnt_any, rd_grant;

    assign any_req = m0_req | m1_req;
    // Grants are masked by rsta directly since the FSM sits in ACTIVE during reset.
    assign open    = (state == ST_ACTIVE) && !rsta;

`ifdef XPMWRAP_SPRAM_ARB_RR_EN
    logic rr_last;

    assign sel1 = m1_req && (!m0_req || !rr_last);

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            rr_last <= 1'b1;
        end else if (gnt_any) begin
            rr_last <= m1_gnt;
        end
    end
`else
    assign sel1 = m1_req && !m0_req;
`endif

    assign m0_gnt     = open && m0_req && !sel1;
    assign m1_gnt     = open && sel1;
    assign gnt_any    = m0_gnt | m1_gnt;
    assign ram_ena    = gnt_any;
    assign ram_wea    = m1_gnt ? m1_we : (m0_gnt ? m0_we : '0);
    assign ram_addra  = sel1 ? m1_addr : m0_addr;
    assign ram_dina   = sel1 ? m1_wdata : m0_wdata;
    assign ram_regcea = 1'b1;
    assign rd_grant   = m1_gnt ? (m1_we == '0) : (m0_gnt && (m0_we == '0));

    assign m0_rdata  = ram_douta;
    assign m1_rdata  = ram_douta;
    assign m0_rvalid = tag1_v && !tag1_own;
    assign m1_rvalid = tag1_v && tag1_own;

    // Tag stage 1 lines up with the RAM output register.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            tag0_v   <= 1'b0;
            tag0_own <= 1'b0;
            tag1_v   <= 1'b0;
            tag1_own <= 1'b0;
        end else begin
            tag0_v   <= rd_grant;
            tag0_own <= m1_gnt;
            tag1_v   <= tag0_v;
            tag1_own <= tag0_own;
        end
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state     <= ST_ACTIVE;
            idle_cnt  <= '0;
            wake_cnt  <= '0;
            ram_sleep <= 1'b0;
        end else begin
            case (state)
                ST_ACTIVE: begin
                    if (any_req) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt != IDLE_MAX) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                    // Enter sleep on the cycle the idle count reaches its limit.
                    if (IDLE_CYCLES != 0 && !any_req && !tag0_v && !tag1_v
                        && idle_cnt >= IDLE_LAST) begin
                        state     <= ST_SLEEP;
                        ram_sleep <= 1'b1;
                    end
                end
                ST_SLEEP: begin
                    if (any_req) begin
                        ram_sleep <= 1'b0;
                        wake_cnt  <= '0;
                        if (WAKE_CYCLES == 0) begin
                            state    <= ST_ACTIVE;
                            idle_cnt <= '0;
                        end else begin
                            state <= ST_WAKE;
                        end
                    end
                end
                ST_WAKE: begin
                    if (wake_cnt == WAKE_LAST) begin
                        state    <= ST_ACTIVE;
                        idle_cnt <= '0;
                    end else begin
                        wake_cnt <= wake_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= ST_ACTIVE;
                    ram_sleep <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xpmwrap_spram_arbiter.sv
// tb/tb_xpmwrap_spram_arbiter.sv - randomized scoreboard bench for xpmwrap_spram_arbiter
module tb_xpmwrap_spram_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NB = 4;

    logic          clka = 1'b0;
    logic          rsta = 1'b1;
    logic          m0_req = 1'b0, m1_req = 1'b0;
    logic [NB-1:0] m0_we = '0, m1_we = '0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          ram_ena, ram_regcea, ram_sleep;
    logic [NB-1:0] ram_wea;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_dina;
    logic [DW-1:0] ram_douta;

    xpmwrap_spram_arbiter #(
        .ADDR_WIDTH_A(AW), .DATA_WIDTH_A(DW), .BYTE_WRITE_WIDTH_A(8),
        .IDLE_CYCLES(16), .WAKE_CYCLES(2)
    ) dut (
        .clka(clka), .rsta(rsta),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_regcea(ram_regcea), .ram_sleep(ram_sleep), .ram_douta(ram_douta)
    );

    always #5 clka = ~clka;

    // Behavioural single-port RAM with two-cycle read latency.
    bit   [DW-1:0] ram_mem [64];
    logic [DW-1:0] ram_p1;
    always @(posedge clka) begin
        if (ram_ena) begin
            for (int b = 0; b < NB; b++)
                if (ram_wea[b]) ram_mem[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
            ram_p1 <= ram_mem[ram_addra];
        end
        if (ram_regcea) ram_douta <= ram_p1;
    end

    typedef struct {
        int          due;
        bit          own;
        logic [31:0] data;
    } rd_t;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    bit   [DW-1:0] mem_ref [64];
    rd_t           rq [$];
    bit            last_win = 1'b1;
    bit   [1:0]    t_req = '0;
    logic [NB-1:0] t_we [2];
    logic [AW-1:0] t_addr [2];
    logic [DW-1:0] t_wdata [2];
    bit   [1:0]    g_exp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive t_* after the edge, check at the falling edge, then advance the model.
    task automatic step(input bit open, input bit sl);
        bit e0, e1, w;
        rd_t r;
        @(posedge clka); #1;
        m0_req = t_req[0]; m0_we = t_we[0]; m0_addr = t_addr[0]; m0_wdata = t_wdata[0];
        m1_req = t_req[1]; m1_we = t_we[1]; m1_addr = t_addr[1]; m1_wdata = t_wdata[1];
        cyc++;
        @(negedge clka);
        e0 = 1'b0; e1 = 1'b0;
        if (open) begin
            if (t_req[0] && t_req[1]) begin
`ifdef XPMWRAP_SPRAM_ARB_RR_EN
                e1 = (last_win == 1'b0);
`else
                e1 = 1'b0;
`endif
                e0 = !e1;
            end else begin
                e0 = t_req[0];
                e1 = t_req[1];
            end
        end
        g_exp = {e1, e0};
        w = e1;
        chk("m0_gnt", 32'(m0_gnt), 32'(e0));
        chk("m1_gnt", 32'(m1_gnt), 32'(e1));
        chk("ram_ena", 32'(ram_ena), 32'(e0 | e1));
        chk("ram_sleep", 32'(ram_sleep), 32'(sl));
        if (e0 | e1) begin
            chk("ram_wea", 32'(ram_wea), 32'(t_we[w]));
            chk("ram_addra", 32'(ram_addra), 32'(t_addr[w]));
            chk("ram_dina", ram_dina, t_wdata[w]);
        end else begin
            chk("ram_wea_idle", 32'(ram_wea), 32'd0);
        end
        if (rq.size() > 0 && rq[0].due == cyc) begin
            chk("m0_rvalid", 32'(m0_rvalid), 32'(rq[0].own == 1'b0));
            chk("m1_rvalid", 32'(m1_rvalid), 32'(rq[0].own == 1'b1));
            chk("rdata", rq[0].own ? m1_rdata : m0_rdata, rq[0].data);
            void'(rq.pop_front());
        end else begin
            chk("m0_rvalid_q", 32'(m0_rvalid), 32'd0);
            chk("m1_rvalid_q", 32'(m1_rvalid), 32'd0);
        end
        if (e0 | e1) begin
            last_win = w;
            if (t_we[w] == '0) begin
                r.due = cyc + 2; r.own = w; r.data = mem_ref[t_addr[w]];
                rq.push_back(r);
            end else begin
                for (int b = 0; b < NB; b++)
                    if (t_we[w][b]) mem_ref[t_addr[w]][8*b +: 8] = t_wdata[w][8*b +: 8];
            end
        end
    endtask

    task automatic set_req(input int k, input bit r, input logic [NB-1:0] we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        t_req[k] = r; t_we[k] = we; t_addr[k] = a; t_wdata[k] = d;
    endtask

    initial begin
        bit [1:0] pend;
        int idle_run;
        for (int k = 0; k < 2; k++) set_req(k, 1'b0, '0, '0, '0);

        // Reset: requests asserted must not be granted.
        m0_req = 1'b1; m1_req = 1'b1;
        repeat (2) @(posedge clka);
        @(negedge clka);
        chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("rst_ena", 32'(ram_ena), 32'd0);
        chk("rst_wea", 32'(ram_wea), 32'd0);
        chk("rst_sleep", 32'(ram_sleep), 32'd0);
        chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
        chk("regcea", 32'(ram_regcea), 32'd1);
        @(posedge clka); #1;
        rsta = 1'b0; m0_req = 1'b0; m1_req = 1'b0;

        // Full write then read by m0.
        set_req(0, 1'b1, 4'b1111, 6'd5, 32'hA1B2C3D4); step(1, 0);
        set_req(0, 1'b1, 4'b0000, 6'd5, '0);           step(1, 0);
        set_req(0, 1'b0, '0, '0, '0);                   repeat (2) step(1, 0);

        // Partial byte write then read by m1.
        set_req(1, 1'b1, 4'b0001, 6'd5, 32'h000000EE); step(1, 0);
        set_req(1, 1'b1, 4'b0000, 6'd5, '0);           step(1, 0);
        set_req(1, 1'b0, '0, '0, '0);                   repeat (2) step(1, 0);
        chk("model_merge", mem_ref[5], 32'hA1B2C3EE);

        // Both requesting for four cycles.
        set_req(0, 1'b1, '0, 6'd1, '0);
        set_req(1, 1'b1, '0, 6'd2, '0);
        repeat (4) step(1, 0);
        set_req(0, 1'b0, '0, '0, '0); set_req(1, 1'b0, '0, '0, '0);
        repeat (2) step(1, 0);

        // Sleep entry after 16 idle cycles, then wake on a held m0 read.
        set_req(0, 1'b1, '0, 6'd5, '0); step(1, 0);
        set_req(0, 1'b0, '0, '0, '0);   repeat (16) step(1, 0);
        set_req(0, 1'b1, '0, 6'd5, '0); step(0, 1);
        step(0, 0);
        step(0, 0);
        step(1, 0);
        set_req(0, 1'b0, '0, '0, '0);   repeat (2) step(1, 0);

        // Reset pulse the cycle after a read grant kills that read.
        set_req(0, 1'b1, '0, 6'd1, '0); step(1, 0);
        @(posedge clka); #1;
        rsta = 1'b1; m0_req = 1'b1; m1_req = 1'b1; cyc++;
        @(negedge clka);
        chk("rp_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("rp_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("rp_ena", 32'(ram_ena), 32'd0);
        chk("rp_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
        chk("rp_sleep", 32'(ram_sleep), 32'd0);
        rq.delete(); last_win = 1'b1;
        rsta = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        set_req(0, 1'b0, '0, '0, '0);  step(1, 0);
        set_req(0, 1'b1, '0, 6'd2, '0); set_req(1, 1'b1, '0, 6'd1, '0); step(1, 0);
        set_req(0, 1'b0, '0, '0, '0); set_req(1, 1'b0, '0, '0, '0);
        repeat (3) step(1, 0);

        // Random traffic; requesters hold until granted, never idle long enough to sleep.
        pend = '0; idle_run = 0;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && ($urandom_range(99) < ((k == 1) ? 55 : 45))) begin
                    pend[k] = 1'b1;
                    set_req(k, 1'b1, ($urandom_range(1) == 1) ? NB'($urandom) : '0,
                            AW'($urandom_range(7)), $urandom);
                end
            end
            if (pend == 2'b00 && idle_run >= 6) begin
                pend[0] = 1'b1;
                set_req(0, 1'b1, '0, AW'($urandom_range(7)), '0);
            end
            t_req = pend;
            step(1, 0);
            idle_run = (pend == 2'b00) ? idle_run + 1 : 0;
            if (g_exp[0]) pend[0] = 1'b0;
            if (g_exp[1]) pend[1] = 1'b0;
        end
        t_req = '0;
        repeat (3) step(1, 0);
        chk("queue_drained", 32'(rq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
